spi_adc_scanner: RTL and testbench

- Wishbone master sequencer sitting directly upstream of the SPI master peripheral. It drives that peripheral's register interface to scan a multi-channel SPI ADC autonomously.
- Each scan asserts chip-select, sends one command byte per channel, polls busy, reads the 8-bit result and deasserts chip-select.
- Results go into a result bank. The CPU reads the bank through a Wishbone slave port, and the block raises an interrupt when a scan completes.

---
 rtl/spi_adc_scanner.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_adc_scanner.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_scanner.sv
// Autonomous SPI ADC scanner: Wishbone master driving an SPI master peripheral,
// plus a Wishbone slave exposing control, status and the per-channel result bank.
module spi_adc_scanner #(
  parameter int          NCH      = 8,
  parameter int          PER_W    = 16,
  parameter logic [31:0] SPI_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic        m_ack_i,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_CSLO, S_CMD, S_POLL, S_RD, S_CSHI, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        ch_q, ch_d;
  logic [PER_W-1:0]  cnt_q, cnt_d;
  logic [PER_W-1:0]  period_q, period_d;
  logic [7:0]        divisor_q, divisor_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              done_q, done_d;
  logic              wb_ack_q, wb_ack_d;
  logic [31:0]       wb_dat_q, wb_dat_d;
  logic              m_cyc_q, m_cyc_d;
  logic              m_we_q, m_we_d;
  logic [31:0]       m_adr_q, m_adr_d;
  logic [31:0]       m_dat_q, m_dat_d;
  logic [7:0]        result_q [NCH];
  logic [7:0]        result_d [NCH];

  logic              wb_req;
  logic [4:0]        wb_off;
  logic              busy;
  logic              issue;
  state_t            issue_st;
  logic              unused_ok;

  assign busy   = (state_q != S_IDLE);
  assign wb_req = wb_cyc_i & wb_stb_i & ~wb_ack_q;
  assign wb_off = wb_adr_i[6:2];

  assign wb_ack_o = wb_ack_q;
  assign wb_dat_o = wb_dat_q;
  assign m_adr_o  = m_adr_q;
  assign m_dat_o  = m_dat_q;
  assign m_sel_o  = 4'hf;
  assign m_cyc_o  = m_cyc_q;
  assign m_stb_o  = m_cyc_q;
  assign m_we_o   = m_we_q;
  assign irq      = done_q & ctrl_q[1];

  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:7], wb_adr_i[1:0], wb_dat_i, m_dat_i};

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    divisor_d = divisor_q;
    ctrl_d    = ctrl_q;
    done_d    = done_q;
    wb_ack_d  = wb_req;
    wb_dat_d  = wb_dat_q;
    m_cyc_d   = m_cyc_q;
    m_we_d    = m_we_q;
    m_adr_d   = m_adr_q;
    m_dat_d   = m_dat_q;
    result_d  = result_q;
    issue     = 1'b0;
    issue_st  = S_IDLE;

    // CPU slave port: the access happens in the request cycle, data is returned with ack.
    if (wb_req && !wb_we_i) begin
      wb_dat_d = '0;
      case (wb_off)
        5'd0: wb_dat_d = {29'd0, ctrl_q};
        5'd1: wb_dat_d = {30'd0, done_q, busy};
        5'd2: wb_dat_d = 32'(period_q);
        5'd3: wb_dat_d = {24'd0, divisor_q};
        default: begin
          if (wb_off[4:3] == 2'b01) begin
            for (int i = 0; i < NCH; i++) begin
              if (wb_off[2:0] == 3'(i)) wb_dat_d = {24'd0, result_q[i]};
            end
          end
        end
      endcase
    end

    if (wb_req && wb_we_i) begin
      case (wb_off)
        5'd0: ctrl_d = wb_dat_i[2:0];
        5'd1: if (wb_dat_i[1]) done_d = 1'b0;
        5'd2: period_d = wb_dat_i[PER_W-1:0];
        5'd3: divisor_d = wb_dat_i[7:0];
        default: ;
      endcase
    end

    if (m_cyc_q && m_ack_i) m_cyc_d = 1'b0;

    // Sequencer; placed after the CPU writes so FIN's DONE set and EN clear win.
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - PER_W'(1);
        end else if (ctrl_q[0]) begin
          state_d  = S_DIV;
          issue    = 1'b1;
          issue_st = S_DIV;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        ch_d    = 3'd0;
        cnt_d   = period_q;
        if (ctrl_q[2]) ctrl_d[0] = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        if (!m_cyc_q) begin
          issue    = 1'b1;
          issue_st = state_q;
        end else if (m_ack_i) begin
          case (state_q)
            S_DIV:  state_d = S_CSLO;
            S_CSLO: state_d = S_CMD;
            S_CMD:  state_d = S_POLL;
            S_POLL: if (!m_dat_i[0]) state_d = S_RD;
            S_RD: begin
              for (int i = 0; i < NCH; i++) begin
                if (ch_q == 3'(i)) result_d[i] = m_dat_i[7:0];
              end
              state_d = S_CSHI;
            end
            S_CSHI: begin
              if (ch_q == 3'(NCH - 1)) begin
                state_d = S_FIN;
              end else begin
                ch_d    = ch_q + 3'd1;
                state_d = S_CSLO;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    if (issue) begin
      m_cyc_d = 1'b1;
      m_we_d  = 1'b1;
      m_adr_d = SPI_BASE;
      m_dat_d = '0;
      case (issue_st)
        S_DIV: begin
          m_adr_d = SPI_BASE + 32'h0C;
          m_dat_d = {24'd0, divisor_q};
        end
        S_CSLO: m_adr_d = SPI_BASE + 32'h08;
        S_CMD:  m_dat_d = {24'd0, 2'b11, ch_q, 3'b000};
        S_POLL: begin
          m_we_d  = 1'b0;
          m_adr_d = SPI_BASE + 32'h04;
        end
        S_RD:   m_we_d = 1'b0;
        S_CSHI: begin
          m_adr_d = SPI_BASE + 32'h08;
          m_dat_d = 32'd1;
        end
        default: m_cyc_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ch_q      <= 3'd0;
      cnt_q     <= '0;
      period_q  <= '0;
      divisor_q <= 8'hff;
      ctrl_q    <= 3'd0;
      done_q    <= 1'b0;
      wb_ack_q  <= 1'b0;
      wb_dat_q  <= '0;
      m_cyc_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_adr_q   <= '0;
      m_dat_q   <= '0;
      for (int i = 0; i < NCH; i++) result_q[i] <= 8'd0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      divisor_q <= divisor_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
      wb_ack_q  <= wb_ack_d;
      wb_dat_q  <= wb_dat_d;
      m_cyc_q   <= m_cyc_d;
      m_we_q    <= m_we_d;
      m_adr_q   <= m_adr_d;
      m_dat_q   <= m_dat_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Bench for spi_adc_scanner: models the SPI master peripheral and the CPU, and
// checks master transfer sequences and the result bank against an abstract scan model.
module tb_spi_adc_scanner;
  localparam int          NCH   = 3;
  localparam int          PER_W = 16;
  localparam logic [31:0] BASE  = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i = 4'hf;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic        wb_ack_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i = '0;
  logic [3:0]  m_sel_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic        m_ack_i = 1'b0;
  logic        irq;

  spi_adc_scanner #(.NCH(NCH), .PER_W(PER_W), .SPI_BASE(BASE)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_ack_i(m_ack_i),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xfer_t;

  int          checks = 0;
  int          errors = 0;
  xfer_t       log_q[$];
  xfer_t       exp_q[$];
  int          poll_cnt [NCH];
  logic [7:0]  rd_val [NCH];
  logic [7:0]  exp_res [NCH];
  bit          toggle_mode = 1'b1;
  bit          stall_pending = 1'b0;
  bit          in_stall = 1'b0;
  int          wait_cnt = 0;
  int          busy_left = 0;
  int          cur_ch = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // SPI master peripheral model: acks each transfer, counts down busy polls, returns data.
  initial begin : responder
    xfer_t       t;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (toggle_mode) begin
        m_ack_i = ~m_ack_i;
      end else if (!reset) begin
        m_ack_i = 1'b0; wait_cnt = 0; in_stall = 1'b0; busy_left = 0;
      end else if (m_ack_i) begin
        m_ack_i = 1'b0;
      end else if (m_cyc_o && m_stb_o) begin
        if (stall_pending && m_we_o && m_adr_o == BASE) begin
          stall_pending = 1'b0; wait_cnt = 50; in_stall = 1'b1;
        end
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          in_stall = 1'b0;
          t.we = m_we_o; t.adr = m_adr_o; t.dat = m_dat_o;
          log_q.push_back(t);
          r = $urandom;
          if (m_we_o && m_adr_o == BASE) begin
            cur_ch = int'(m_dat_o[5:3]);
            busy_left = (cur_ch < NCH) ? poll_cnt[cur_ch] : 0;
          end else if (!m_we_o && m_adr_o == BASE + 32'h4) begin
            r[0] = (busy_left > 0);
            if (busy_left > 0) busy_left--;
          end else if (!m_we_o && m_adr_o == BASE) begin
            r[7:0] = (cur_ch < NCH) ? rd_val[cur_ch] : 8'h00;
          end
          m_dat_i = r;
          m_ack_i = 1'b1;
        end
      end
    end
  end

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rdat);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    @(negedge clk);
    chk("wb_ack", 32'(wb_ack_o), 32'd1);
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    wb_xfer(1'b1, adr, dat, d);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
    wb_xfer(1'b0, adr, 32'd0, rdat);
  endtask

  task automatic push(input bit we, input logic [31:0] a, input logic [31:0] d);
    xfer_t t;
    t.we = we; t.adr = a; t.dat = d;
    exp_q.push_back(t);
  endtask

  // Expected scan: divisor, then per channel CS low, command, polls, read, CS high.
  task automatic build_exp(input logic [7:0] div);
    exp_q.delete();
    push(1'b1, BASE + 32'h0C, 32'(div));
    for (int ch = 0; ch < NCH; ch++) begin
      push(1'b1, BASE + 32'h08, 32'd0);
      push(1'b1, BASE, 32'(192 + 8 * ch));
      for (int p = 0; p <= poll_cnt[ch]; p++) push(1'b0, BASE + 32'h04, 32'd0);
      push(1'b0, BASE, 32'd0);
      push(1'b1, BASE + 32'h08, 32'd1);
      exp_res[ch] = rd_val[ch];
    end
  endtask

  task automatic new_scan_data();
    for (int ch = 0; ch < NCH; ch++) begin
      poll_cnt[ch] = int'($urandom_range(0, 3));
      rd_val[ch]   = 8'($urandom_range(1, 255));
    end
  endtask

  task automatic check_xfers(input string tag);
    chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({tag, "_we"}, 32'(log_q[i].we), 32'(exp_q[i].we));
      chk({tag, "_adr"}, log_q[i].adr, exp_q[i].adr);
      if (exp_q[i].we) chk({tag, "_dat"}, log_q[i].dat, exp_q[i].dat);
    end
  endtask

  task automatic check_results(input string tag);
    logic [31:0] rd;
    for (int ch = 0; ch < NCH; ch++) begin
      wb_read(32'h20 + 32'(4 * ch), rd);
      chk({tag, "_result"}, rd, 32'(exp_res[ch]));
    end
  endtask

  task automatic wait_done();
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      wb_read(32'h04, s);
      n++;
    end while (!s[1] && n < 500);
    chk("scan_done", 32'(s[1]), 32'd1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    logic [31:0] s_adr;
    logic [31:0] s_dat;
    logic [7:0]  div;
    int          n;
    bit          ok;

    // Reset hold with the master ack toggling.
    repeat (4) begin
      @(negedge clk); #1;
      chk("rst_cyc", 32'(m_cyc_o), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_sel", 32'(m_sel_o), 32'hf);
      chk("rst_wback", 32'(wb_ack_o), 32'd0);
    end
    toggle_mode = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    wb_read(32'h00, rd); chk("rst_ctrl", rd, 32'd0);
    wb_read(32'h04, rd); chk("rst_status", rd, 32'd0);
    wb_read(32'h08, rd); chk("rst_period", rd, 32'd0);
    wb_read(32'h0C, rd); chk("rst_divisor", rd, 32'hff);
    for (int ch = 0; ch < NCH; ch++) begin
      wb_read(32'h20 + 32'(4 * ch), rd); chk("rst_result", rd, 32'd0);
    end
    wb_write(32'h14, 32'hffff_ffff);
    wb_read(32'h14, rd); chk("unmapped_rd", rd, 32'd0);
    wb_read(32'h20 + 32'(4 * NCH), rd); chk("result_oob", rd, 32'd0);
    wb_read(32'h00, rd); chk("unmapped_wr_ctrl", rd, 32'd0);

    // Directed one-shot scan: channels 0/1 busy twice then return 0x5A / 0xC3.
    poll_cnt[0] = 2; rd_val[0] = 8'h5A;
    poll_cnt[1] = 2; rd_val[1] = 8'hC3;
    poll_cnt[2] = int'($urandom_range(0, 3)); rd_val[2] = 8'($urandom_range(1, 255));
    rd = $urandom;
    div = rd[7:0];
    wb_write(32'h0C, rd);
    wb_read(32'h0C, rd); chk("divisor_rb", rd, 32'(div));
    build_exp(div);
    log_q.delete();
    wb_write(32'h00, 32'h5);
    wait_done();
    check_xfers("scan1");
    check_results("scan1");
    wb_read(32'h00, rd); chk("oneshot_en_clr", rd, 32'h4);
    wb_read(32'h04, rd); chk("scan1_status", rd, 32'h2);
    chk("scan1_irq_off", 32'(irq), 32'd0);

    // Interrupt enable and write-1-clear of DONE.
    wb_write(32'h00, 32'h6);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    wb_write(32'h04, 32'h2);
    chk("irq_clr", 32'(irq), 32'd0);
    wb_read(32'h04, rd); chk("status_clr", rd, 32'd0);

    // Continuous scans with PERIOD=100, then EN cleared mid-scan.
    wb_write(32'h08, 32'd100);
    wb_read(32'h08, rd); chk("period_rb", rd, 32'd100);
    new_scan_data();
    build_exp(div);
    log_q.delete();
    wb_write(32'h00, 32'h3);
    n = 0;
    while (!irq && n < 3000) begin @(negedge clk); n++; end
    chk("scanA_irq", 32'(irq), 32'd1);
    check_xfers("scanA");
    new_scan_data();
    build_exp(div);
    log_q.delete();
    n = 0;
    while (!m_cyc_o && n < 500) begin @(negedge clk); n++; end
    chk("period_gap", 32'(n), 32'd101);
    wb_write(32'h00, 32'h0);
    n = 0;
    while (log_q.size() < exp_q.size() && n < 3000) begin @(negedge clk); n++; end
    repeat (300) @(negedge clk);
    chk("en_clr_idle", 32'(m_cyc_o), 32'd0);
    check_xfers("scanB");
    check_results("scanB");
    wb_read(32'h04, rd); chk("scanB_status", rd, 32'h2);

    // Stalled ack during the first command write.
    wb_write(32'h08, 32'd0);
    wb_write(32'h04, 32'h2);
    new_scan_data();
    build_exp(div);
    log_q.delete();
    stall_pending = 1'b1;
    wb_write(32'h00, 32'h5);
    n = 0;
    while (!in_stall && n < 200) begin @(negedge clk); n++; end
    chk("stall_seen", 32'(in_stall), 32'd1);
    s_adr = m_adr_o; s_dat = m_dat_o; ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (!(m_cyc_o && m_stb_o && m_we_o && m_adr_o == s_adr && m_dat_o == s_dat)) ok = 1'b0;
    end
    chk("stall_stable", 32'(ok), 32'd1);
    chk("stall_adr", s_adr, BASE);
    chk("stall_dat", s_dat, 32'hC0);
    wb_read(32'h04, rd); chk("stall_busy", 32'(rd[0]), 32'd1);
    wait_done();
    check_xfers("stall");
    check_results("stall");

    // Asynchronous reset in the middle of polling.
    wb_write(32'h04, 32'h2);
    new_scan_data();
    poll_cnt[0] = 30;
    wb_write(32'h00, 32'h5);
    n = 0;
    while (!(m_cyc_o && !m_we_o && m_adr_o == BASE + 32'h4) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("poll_seen", 32'(m_cyc_o && !m_we_o), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_cyc", 32'(m_cyc_o), 32'd0);
    chk("arst_stb", 32'(m_stb_o), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ok = 1'b1;
    repeat (20) begin @(negedge clk); if (m_cyc_o) ok = 1'b0; end
    chk("arst_idle", 32'(ok), 32'd1);
    wb_read(32'h04, rd); chk("arst_status", rd, 32'd0);
    wb_read(32'h00, rd); chk("arst_ctrl", rd, 32'd0);
    wb_read(32'h0C, rd); chk("arst_divisor", rd, 32'hff);
    for (int ch = 0; ch < NCH; ch++) exp_res[ch] = 8'd0;
    check_results("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
